// File: rtl/rtc_adj_seq.sv
// rtc_adj_seq: masters the RTC register bus to apply a one-shot time offset.
// Sequence: read RTC_CTL, keep intxms_sel, write NS/SC offsets, write RTC_CTL
// with offset_valid, then hold the bus quiet long enough for the RTC's
// offset_valid self-clear before reporting done.
// Optional feature macro: RTC_ADJ_TICK_EN adds a TICK_INC write ahead of the
// offset writes when the request carries a valid tick value.

`ifndef RTC_BLK_ADDR
`define RTC_BLK_ADDR 24'h80_0000
`endif
`ifndef RTC_CTL_ADDR
`define RTC_CTL_ADDR 8'h00
`endif
`ifndef TICK_INC_ADDR
`define TICK_INC_ADDR 8'h04
`endif
`ifndef NS_OFST_ADDR
`define NS_OFST_ADDR 8'h08
`endif
`ifndef SC_OFST_ADDR0
`define SC_OFST_ADDR0 8'h0C
`endif
`ifndef SC_OFST_ADDR1
`define SC_OFST_ADDR1 8'h10
`endif

module rtc_adj_seq #(
    parameter logic [23:0] BLK_ADDR  = `RTC_BLK_ADDR,
    parameter int          GUARD_CYC = 4
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst_n,
    input  logic        adj_req_i,
    input  logic [47:0] adj_sc_i,
    input  logic [31:0] adj_ns_i,
`ifdef RTC_ADJ_TICK_EN
    input  logic [31:0] adj_tick_i,
    input  logic        adj_tick_vld_i,
`endif
    output logic        adj_busy_o,
    output logic        adj_done_o,
    output logic        adj_drop_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic        m_rd_ce_o,
    output logic        m_wr_ce_o,
    input  logic [31:0] m_data_i
);

    localparam int CW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    // The RTC needs 3 write-free cycles to self-clear offset_valid.
    if (GUARD_CYC < 3) begin : g_guard_check
        $error("rtc_adj_seq: GUARD_CYC must be at least 3");
    end

    typedef enum logic [3:0] {
        IDLE,
        RD_CTL,
        RD_CAP,
`ifdef RTC_ADJ_TICK_EN
        WR_TICK,
`endif
        WR_NS,
        WR_SC0,
        WR_SC1,
        WR_CTL,
        GUARD,
        DONE
    } state_t;

    state_t        state;
    logic [47:0]   sc_q;
    logic [31:0]   ns_q;
    logic          ctl_q;
    logic [CW-1:0] guard_cnt;
`ifdef RTC_ADJ_TICK_EN
    logic [31:0]   tick_q;
    logic          tick_vld_q;
`endif

    // Only intxms_sel of the RTC_CTL readback is kept.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{m_data_i[31:3], m_data_i[1:0]};

    // Sequencer: every output is a register updated together with the state.
    // m_addr_o resets to 0 and carries {BLK_ADDR, offset} from the first strobe on.
    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            state      <= IDLE;
            sc_q       <= '0;
            ns_q       <= '0;
            ctl_q      <= 1'b0;
            guard_cnt  <= '0;
`ifdef RTC_ADJ_TICK_EN
            tick_q     <= '0;
            tick_vld_q <= 1'b0;
`endif
            adj_busy_o <= 1'b0;
            adj_done_o <= 1'b0;
            adj_drop_o <= 1'b0;
            m_addr_o   <= '0;
            m_data_o   <= '0;
            m_rd_ce_o  <= 1'b0;
            m_wr_ce_o  <= 1'b0;
        end else begin
            m_rd_ce_o  <= 1'b0;
            m_wr_ce_o  <= 1'b0;
            adj_done_o <= 1'b0;
            adj_drop_o <= adj_req_i && (state != IDLE);
            case (state)
                IDLE: begin
                    if (adj_req_i) begin
                        sc_q       <= adj_sc_i;
                        ns_q       <= adj_ns_i;
`ifdef RTC_ADJ_TICK_EN
                        tick_q     <= adj_tick_i;
                        tick_vld_q <= adj_tick_vld_i;
`endif
                        adj_busy_o <= 1'b1;
                        m_rd_ce_o  <= 1'b1;
                        m_addr_o   <= {BLK_ADDR, `RTC_CTL_ADDR};
                        state      <= RD_CTL;
                    end
                end
                RD_CTL: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    // RTC read data is registered: valid the cycle after rd_ce.
                    ctl_q <= m_data_i[2];
`ifdef RTC_ADJ_TICK_EN
                    if (tick_vld_q) begin
                        m_wr_ce_o <= 1'b1;
                        m_addr_o  <= {BLK_ADDR, `TICK_INC_ADDR};
                        m_data_o  <= tick_q;
                        state     <= WR_TICK;
                    end else begin
                        m_wr_ce_o <= 1'b1;
                        m_addr_o  <= {BLK_ADDR, `NS_OFST_ADDR};
                        m_data_o  <= ns_q;
                        state     <= WR_NS;
                    end
`else
                    m_wr_ce_o <= 1'b1;
                    m_addr_o  <= {BLK_ADDR, `NS_OFST_ADDR};
                    m_data_o  <= ns_q;
                    state     <= WR_NS;
`endif
                end
`ifdef RTC_ADJ_TICK_EN
                WR_TICK: begin
                    m_wr_ce_o <= 1'b1;
                    m_addr_o  <= {BLK_ADDR, `NS_OFST_ADDR};
                    m_data_o  <= ns_q;
                    state     <= WR_NS;
                end
`endif
                WR_NS: begin
                    m_wr_ce_o <= 1'b1;
                    m_addr_o  <= {BLK_ADDR, `SC_OFST_ADDR0};
                    m_data_o  <= {16'h0, sc_q[47:32]};
                    state     <= WR_SC0;
                end
                WR_SC0: begin
                    m_wr_ce_o <= 1'b1;
                    m_addr_o  <= {BLK_ADDR, `SC_OFST_ADDR1};
                    m_data_o  <= sc_q[31:0];
                    state     <= WR_SC1;
                end
                WR_SC1: begin
                    // offset_valid=1, clear_rtc=0, intxms_sel preserved.
                    m_wr_ce_o <= 1'b1;
                    m_addr_o  <= {BLK_ADDR, `RTC_CTL_ADDR};
                    m_data_o  <= {29'h0, ctl_q, 1'b0, 1'b1};
                    state     <= WR_CTL;
                end
                WR_CTL: begin
                    guard_cnt <= CW'(GUARD_CYC - 1);
                    state     <= GUARD;
                end
                GUARD: begin
                    if (guard_cnt == '0) begin
                        adj_done_o <= 1'b1;
                        state      <= DONE;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                DONE: begin
                    adj_busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    adj_busy_o <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_adj_seq.sv
// Bench for rtc_adj_seq: directed requests, scoreboard queues for bus
// transactions, done and drop pulses, plus a small RTC model that returns
// RTC_CTL readback and tracks the offset_valid self-clear.
// Build with RTC_ADJ_TICK_EN defined to also exercise the TICK_INC write.

`ifndef RTC_BLK_ADDR
`define RTC_BLK_ADDR 24'h80_0000
`endif
`ifndef RTC_CTL_ADDR
`define RTC_CTL_ADDR 8'h00
`endif
`ifndef TICK_INC_ADDR
`define TICK_INC_ADDR 8'h04
`endif
`ifndef NS_OFST_ADDR
`define NS_OFST_ADDR 8'h08
`endif
`ifndef SC_OFST_ADDR0
`define SC_OFST_ADDR0 8'h0C
`endif
`ifndef SC_OFST_ADDR1
`define SC_OFST_ADDR1 8'h10
`endif

module tb_rtc_adj_seq;

    localparam logic [23:0] BLK = `RTC_BLK_ADDR;
    localparam int GUARD = 4;

    logic        clk;
    logic        rst_n;
    logic        adj_req;
    logic [47:0] adj_sc;
    logic [31:0] adj_ns;
    logic [31:0] adj_tick;
    logic        adj_tick_vld;
    logic        adj_busy;
    logic        adj_done;
    logic        adj_drop;
    logic [31:0] m_addr;
    logic [31:0] m_data_o;
    logic        m_rd_ce;
    logic        m_wr_ce;
    logic [31:0] m_data_i;

    rtc_adj_seq #(.BLK_ADDR(BLK), .GUARD_CYC(GUARD)) dut (
        .bus2ip_clk   (clk),
        .bus2ip_rst_n (rst_n),
        .adj_req_i    (adj_req),
        .adj_sc_i     (adj_sc),
        .adj_ns_i     (adj_ns),
`ifdef RTC_ADJ_TICK_EN
        .adj_tick_i     (adj_tick),
        .adj_tick_vld_i (adj_tick_vld),
`endif
        .adj_busy_o   (adj_busy),
        .adj_done_o   (adj_done),
        .adj_drop_o   (adj_drop),
        .m_addr_o     (m_addr),
        .m_data_o     (m_data_o),
        .m_rd_ce_o    (m_rd_ce),
        .m_wr_ce_o    (m_wr_ce),
        .m_data_i     (m_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } bus_t;

    bus_t bus_q[$];
    int   done_q[$];
    int   drop_q[$];

    // RTC model: registered readback of RTC_CTL; junk otherwise (bit2 clear).
    logic [31:0] rtc_ctl_val = 32'h0;
    always @(posedge clk) m_data_i <= m_rd_ce ? rtc_ctl_val : 32'hFFFF_FFFB;

    // offset_valid model and guard-gap tracking.
    logic ov = 1'b0;
    int   ov_free = 0;
    int   ov_pulses = 0;
    int   last_ctl = -1;
    logic gap_pend = 1'b0;

    // Monitor: pops scoreboard entries whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_rd_ce || m_wr_ce) begin
                bus_t e;
                $display("txn cyc=%0d %s addr=%08h data=%08h", cyc, m_wr_ce ? "WR" : "RD", m_addr, m_data_o);
                chk("one_strobe", !(m_rd_ce && m_wr_ce), {m_rd_ce, m_wr_ce}, 2'b00);
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus", 1'b0, m_addr, 0);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_kind", m_wr_ce == e.wr, m_wr_ce, e.wr);
                    chk("bus_addr", m_addr == e.addr, m_addr, e.addr);
                    if (e.wr) chk("bus_data", m_data_o == e.data, m_data_o, e.data);
                    chk("bus_cycle", cyc == e.cyc, cyc, e.cyc);
                end
            end
            if (m_wr_ce) begin
                chk("ov_clear_before_wr", ov == 1'b0, ov, 0);
                if (gap_pend) begin
                    chk("guard_gap", (cyc - last_ctl - 1) >= GUARD, cyc - last_ctl - 1, GUARD);
                    gap_pend = 1'b0;
                end
                if (m_addr[7:0] == `RTC_CTL_ADDR && m_data_o[0]) begin
                    ov = 1'b1;
                    ov_free = 0;
                    ov_pulses++;
                    last_ctl = cyc;
                    gap_pend = 1'b1;
                end
            end else if (ov) begin
                ov_free++;
                if (ov_free >= 3) ov = 1'b0;
            end
            if (adj_done) begin
                $display("done cyc=%0d", cyc);
                if (done_q.size() == 0) chk("unexpected_done", 1'b0, cyc, 0);
                else begin
                    int d;
                    d = done_q.pop_front();
                    chk("done_cycle", cyc == d, cyc, d);
                end
            end
            if (adj_drop) begin
                $display("drop cyc=%0d", cyc);
                if (drop_q.size() == 0) chk("unexpected_drop", 1'b0, cyc, 0);
                else begin
                    int d;
                    d = drop_q.pop_front();
                    chk("drop_cycle", cyc == d, cyc, d);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one request in the current cycle and push the expected events.
    // nev limits how many bus events are expected (reset-abort case).
    task automatic issue(input logic [47:0] sc, input logic [31:0] ns, input logic [31:0] ctlv,
                         input logic tv, input logic [31:0] tk, input int nev);
        int   c;
        int   off;
        bus_t ev[$];
        c   = cyc;
        off = tv ? 1 : 0;
        rtc_ctl_val  = ctlv;
        adj_req      = 1'b1;
        adj_sc       = sc;
        adj_ns       = ns;
        adj_tick     = tk;
        adj_tick_vld = tv;
        ev.push_back('{1'b0, {BLK, `RTC_CTL_ADDR}, 32'h0, c + 1});
        if (tv) ev.push_back('{1'b1, {BLK, `TICK_INC_ADDR}, tk, c + 3});
        ev.push_back('{1'b1, {BLK, `NS_OFST_ADDR}, ns, c + 3 + off});
        ev.push_back('{1'b1, {BLK, `SC_OFST_ADDR0}, {16'h0, sc[47:32]}, c + 4 + off});
        ev.push_back('{1'b1, {BLK, `SC_OFST_ADDR1}, sc[31:0], c + 5 + off});
        ev.push_back('{1'b1, {BLK, `RTC_CTL_ADDR}, ctlv[2] ? 32'h5 : 32'h1, c + 6 + off});
        for (int i = 0; i < ev.size() && i < nev; i++) bus_q.push_back(ev[i]);
        if (nev >= ev.size()) done_q.push_back(c + 11 + off);
        step(1);
        // Operands must be frozen at acceptance.
        adj_req      = 1'b0;
        adj_sc       = {$urandom, $urandom};
        adj_ns       = $urandom;
        adj_tick     = $urandom;
        adj_tick_vld = 1'b0;
    endtask

    task automatic pulse_req(input int drop_at);
        adj_req = 1'b1;
        adj_sc  = 48'hFFFF_0000_BEEF;
        adj_ns  = 32'h0BAD_F00D;
        drop_q.push_back(drop_at);
        step(1);
        adj_req = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, adj_busy == 1'b0, adj_busy, 0);
        chk({tag, "_done"}, adj_done == 1'b0, adj_done, 0);
        chk({tag, "_drop"}, adj_drop == 1'b0, adj_drop, 0);
        chk({tag, "_addr"}, m_addr == 32'h0, m_addr, 0);
        chk({tag, "_data"}, m_data_o == 32'h0, m_data_o, 0);
        chk({tag, "_rd"}, m_rd_ce == 1'b0, m_rd_ce, 0);
        chk({tag, "_wr"}, m_wr_ce == 1'b0, m_wr_ce, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int p0;
        rst_n = 1'b0;
        adj_req = 1'b0;
        adj_sc = '0;
        adj_ns = '0;
        adj_tick = '0;
        adj_tick_vld = 1'b0;
        step(3);
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        // 1: basic sequence, intxms_sel=1 preserved
        issue(48'h0000_0000_0012, 32'h1DCD_6500, 32'h4, 1'b0, 32'h0, 99);
        step(14);

        // 2: intxms_sel=0, one offset_valid pulse
        p0 = ov_pulses;
        issue(48'h1234_5678_9ABC, 32'h0000_0001, 32'h0, 1'b0, 32'h0, 99);
        step(14);
        chk("ov_pulse_once", ov_pulses == p0 + 1, ov_pulses - p0, 1);

        // 3: requests during WR_SC0 and DONE are dropped
        c = cyc;
        issue(48'h0000_0000_0003, 32'h0000_0100, 32'h4, 1'b0, 32'h0, 99);
        goto(c + 4);
        pulse_req(c + 5);
        goto(c + 11);
        pulse_req(c + 12);
        step(6);
        chk("busy_idle_after_drop", adj_busy == 1'b0, adj_busy, 0);

        // 4: back-to-back, second request in the first cycle after DONE
        c = cyc;
        issue(48'h0000_0000_0021, 32'h0000_2222, 32'h0, 1'b0, 32'h0, 99);
        goto(c + 12);
        chk("busy_low_b2b", adj_busy == 1'b0, adj_busy, 0);
        issue(48'h0000_0000_0022, 32'h0000_3333, 32'h4, 1'b0, 32'h0, 99);
        step(14);

        // 5: reset during WR_SC0
        c = cyc;
        issue(48'h0000_0001_0005, 32'h0000_5555, 32'h4, 1'b0, 32'h0, 3);
        goto(c + 4);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(10);
        issue(48'h0000_0000_0006, 32'h0000_6666, 32'h4, 1'b0, 32'h0, 99);
        step(14);

`ifdef RTC_ADJ_TICK_EN
        // 6: tick write inserted when valid, skipped otherwise
        issue(48'h0000_0000_0007, 32'h0000_7777, 32'h4, 1'b1, 32'h0640_0000, 99);
        step(15);
        issue(48'h0000_0000_0008, 32'h0000_8888, 32'h0, 1'b0, 32'h0640_0000, 99);
        step(14);
`endif

        chk("bus_q_empty", bus_q.size() == 0, bus_q.size(), 0);
        chk("done_q_empty", done_q.size() == 0, done_q.size(), 0);
        chk("drop_q_empty", drop_q.size() == 0, drop_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
